// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// 8N1 UART transmitter fed by a small byte FIFO. Bytes are pushed with a
// valid/ready handshake and shifted out LSB-first. Queued bytes follow each
// other with no idle gap between frames.
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   div_i      clocks per bit, sampled at frame start (values < 2 act as 2)
//   wr_valid   byte offered
//   wr_data    byte to send
//   wr_ready   FIFO can accept a byte
//   txd        serial line, idle high, driven from a flop
//   busy       frame in progress or FIFO non-empty
//   fifo_count bytes queued, excluding the byte in flight
//   tx_done    one-cycle pulse during the final clock of each stop bit
module uart_tx_fifo #(
  parameter int DIV_WIDTH  = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_WIDTH-1:0]          div_i,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q;
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_d;
  logic [DIV_WIDTH-1:0] bit_div_q;
  logic [DIV_WIDTH-1:0] clk_cnt_q;
  logic [DIV_WIDTH-1:0] div_eff;
  logic [2:0]           bit_cnt_q;
  logic [7:0]           shift_q;
  logic                 txd_q;
  logic                 tx_done_q;
  logic                 push;
  logic                 pop;
  logic                 bit_end;

  // A divisor of 0 or 1 cannot produce a sensible bit period.
  assign div_eff  = (div_i < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_i;
  assign bit_end  = (clk_cnt_q == '0);

  // Ready depends only on registered count, so a pop in the same cycle
  // never opens a slot for a push while full.
  assign wr_ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign push     = wr_valid && wr_ready;

  // Pop from IDLE, or on the last stop-bit cycle to chain the next frame
  // straight into START without an idle cycle.
  assign pop = (count_q != '0) &&
               ((state_q == IDLE) || ((state_q == STOP) && bit_end));

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage has no reset; only pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_div_q <= DIV_WIDTH'(2);
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      txd_q     <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      // Line outputs follow the current state one clock later, so every
      // bit on txd lasts exactly bit_div clocks.
      txd_q     <= (state_q == START) ? 1'b0 :
                   (state_q == DATA)  ? shift_q[0] : 1'b1;
      tx_done_q <= (state_q == STOP) && bit_end;

      case (state_q)
        IDLE: ;
        START: begin
          if (bit_end) begin
            clk_cnt_q <= bit_div_q - DIV_WIDTH'(1);
            state_q   <= DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q - DIV_WIDTH'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt_q <= bit_div_q - DIV_WIDTH'(1);
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q - DIV_WIDTH'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            state_q <= IDLE;
          end else begin
            clk_cnt_q <= clk_cnt_q - DIV_WIDTH'(1);
          end
        end
        default: state_q <= IDLE;
      endcase

      // Frame load overrides the per-state updates above.
      if (pop) begin
        shift_q   <= mem_q[rd_ptr_q];
        bit_div_q <= div_eff;
        clk_cnt_q <= div_eff - DIV_WIDTH'(1);
        bit_cnt_q <= '0;
        state_q   <= START;
      end
    end
  end

  assign txd        = txd_q;
  assign tx_done    = tx_done_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: directed scenarios plus a randomized burst,
// checked against a serial receiver model and a queue of accepted bytes.
module tb_uart_tx_fifo;
  localparam int DW = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] div_i = DW'(217);
  logic          wr_valid = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_ready;
  logic          txd;
  logic          busy;
  logic [2:0]    fifo_count;
  logic          tx_done;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DIV_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .div_i(div_i), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready), .txd(txd), .busy(busy),
    .fifo_count(fifo_count), .tx_done(tx_done)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference data: bytes accepted by the handshake, and what the line carried.
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         fall_q[$];
  int         done_q[$];
  int         push_q[$];
  int         exp_div = 217;
  int         rx_idx = -1;
  int         rx_d = 2;
  int         rx_err = 0;
  int         busy_after_done = -1;
  int         last_stall = 0;
  logic       rx_cur = 1'b1;
  logic       txd_prev = 1'b1;
  logic       done_prev = 1'b0;
  logic [7:0] rx_byte = 8'h00;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Serial receiver: on a falling edge it expects a 10-bit 8N1 frame of
  // exp_div clocks per bit, and requires the line to hold steady for each bit.
  initial begin : rx_proc
    int j;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rx_idx    = -1;
        txd_prev  = 1'b1;
        done_prev = 1'b0;
      end else begin
        if (done_prev) busy_after_done = int'(busy);
        done_prev = tx_done;
        if (tx_done) done_q.push_back(cyc);
        if (rx_idx < 0 && txd_prev && !txd) begin
          rx_idx = 0;
          rx_d   = exp_div;
          fall_q.push_back(cyc);
        end else if (rx_idx >= 0) begin
          rx_idx++;
        end
        if (rx_idx >= 0) begin
          if (rx_idx % rx_d == 0) begin
            j      = rx_idx / rx_d;
            rx_cur = txd;
            if (j == 0 && txd !== 1'b0) rx_err++;
            if (j >= 1 && j <= 8) rx_byte[j-1] = txd;
            if (j == 9 && txd !== 1'b1) rx_err++;
          end else if (txd !== rx_cur) begin
            rx_err++;
          end
          if (rx_idx == 10 * rx_d - 1) begin
            rx_q.push_back(rx_byte);
            rx_idx = -1;
          end
        end
        txd_prev = txd;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Called just after a posedge; returns #1 after the edge that pushed.
  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    wr_valid = 1'b1;
    wr_data  = b;
    do begin
      @(negedge clk);
      n++;
    end while (!wr_ready && n < 5000);
    chk("push_ready", 32'(wr_ready), 32'd1);
    if (wr_ready) exp_q.push_back(b);
    last_stall = n;
    @(posedge clk);
    #1;
    push_q.push_back(cyc);
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || rx_idx >= 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_in_time", 32'(n < budget), 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_falls(input int nf, input int budget);
    int n = 0;
    while (fall_q.size() < nf && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("fall_in_time", 32'(n < budget), 32'd1);
  endtask

  task automatic check_stream(input string tag);
    chk($sformatf("%s_count", tag), 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    chk($sformatf("%s_rx_err", tag), 32'(rx_err), 32'd0);
  endtask

  task automatic clear_all();
    exp_q.delete();
    rx_q.delete();
    fall_q.delete();
    done_q.delete();
    push_q.delete();
    busy_after_done = -1;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int nf;
    int nd;
    int gap;
    int d;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_tx_done", 32'(tx_done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single byte 'O' at 217 clocks per bit
    div_i = DW'(217);
    exp_div = 217;
    push_byte(8'h4F);
    wait_idle(4000);
    chk("t1_falls", 32'(fall_q.size()), 32'd1);
    chk("t1_push_to_fall", 32'(fall_q[0] - push_q[0]), 32'd2);
    chk("t1_dones", 32'(done_q.size()), 32'd1);
    chk("t1_fall_to_done", 32'(done_q[0] - fall_q[0]), 32'd2169);
    chk("t1_busy_after_done", 32'(busy_after_done), 32'd0);
    check_stream("t1");
    clear_all();

    // 2: "OK\n" on consecutive cycles; count after each push: the first
    // byte is popped on the second push edge, so 1,1,2.
    push_byte(8'h4F);
    chk("t2_count0", 32'(fifo_count), 32'd1);
    chk("t2_ready0", 32'(wr_ready), 32'd1);
    push_byte(8'h4B);
    chk("t2_count1", 32'(fifo_count), 32'd1);
    chk("t2_ready1", 32'(wr_ready), 32'd1);
    push_byte(8'h0A);
    chk("t2_count2", 32'(fifo_count), 32'd2);
    chk("t2_ready2", 32'(wr_ready), 32'd1);
    wait_idle(8000);
    chk("t2_falls", 32'(fall_q.size()), 32'd3);
    chk("t2_gap1", 32'(fall_q[1] - fall_q[0]), 32'd2170);
    chk("t2_gap2", 32'(fall_q[2] - fall_q[1]), 32'd2170);
    chk("t2_dones", 32'(done_q.size()), 32'd3);
    chk("t2_count_end", 32'(fifo_count), 32'd0);
    check_stream("t2");
    clear_all();

    // 3: six bytes into a 4-deep FIFO at 4 clocks per bit
    div_i = DW'(4);
    exp_div = 4;
    for (int i = 1; i <= 5; i++) begin
      push_byte(8'(i));
      chk($sformatf("t3_count%0d", i), 32'(fifo_count), (i == 1) ? 32'd1 : 32'(i - 1));
    end
    chk("t3_full_ready", 32'(wr_ready), 32'd0);
    push_byte(8'h06);
    chk("t3_stalled", 32'(last_stall > 1), 32'd1);
    chk("t3_push6_after_pop", 32'(push_q[5] - done_q[0]), 32'd1);
    chk("t3_count6", 32'(fifo_count), 32'd4);
    wait_idle(1000);
    chk("t3_falls", 32'(fall_q.size()), 32'd6);
    for (int i = 1; i < fall_q.size(); i++)
      chk($sformatf("t3_gap%0d", i), 32'(fall_q[i] - fall_q[i-1]), 32'd40);
    chk("t3_dones", 32'(done_q.size()), 32'd6);
    check_stream("t3");
    clear_all();

    // 4: divisor changed during DATA applies only to the next frame
    push_byte(8'hA5);
    push_byte(8'h3C);
    wait_falls(1, 100);
    repeat (6) @(negedge clk);
    div_i = DW'(8);
    exp_div = 8;
    wait_idle(1000);
    chk("t4_len1", 32'(done_q[0] - fall_q[0]), 32'd39);
    chk("t4_gap", 32'(fall_q[1] - fall_q[0]), 32'd40);
    chk("t4_len2", 32'(done_q[1] - fall_q[1]), 32'd79);
    check_stream("t4");
    clear_all();

    // 5: divisors 0 and 1 behave as 2
    for (int v = 0; v < 2; v++) begin
      div_i = DW'(v);
      exp_div = 2;
      push_byte(8'h55);
      wait_idle(200);
      chk($sformatf("t5_len_div%0d", v), 32'(done_q[0] - fall_q[0]), 32'd19);
      check_stream($sformatf("t5_div%0d", v));
      clear_all();
    end

    // 6: reset during bit 3 of the first of two queued frames
    div_i = DW'(217);
    exp_div = 217;
    push_byte(8'hFF);
    push_byte(8'h00);
    wait_falls(1, 100);
    repeat (4 * 217 + 100) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t6_txd", 32'(txd), 32'd1);
    chk("t6_fifo_count", 32'(fifo_count), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    nf = fall_q.size();
    nd = done_q.size();
    repeat (3000) @(negedge clk);
    chk("t6_no_fall", 32'(fall_q.size()), 32'(nf));
    chk("t6_no_done", 32'(nd + done_q.size()), 32'd0);
    chk("t6_no_rx", 32'(rx_q.size()), 32'd0);
    clear_all();
    @(posedge clk);
    #1;
    div_i = DW'(4);
    exp_div = 4;
    push_byte(8'h5A);
    wait_idle(200);
    check_stream("t6_recover");
    clear_all();

    // Randomized burst with random divisor and gaps
    d = int'($urandom_range(2, 5));
    div_i = DW'(d);
    exp_div = d;
    for (int i = 0; i < 16; i++) begin
      gap = int'($urandom_range(0, 3));
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      push_byte(8'($urandom_range(0, 255)));
    end
    wait_idle(2000);
    chk("rnd_dones", 32'(done_q.size()), 32'd16);
    check_stream("rnd");
    clear_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
